// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg
// Shared types and helpers for the sequential non-restoring divider.
//   divState_t   : controller states (IDLE, CALC, FIX, DONE)
//   counterWidth : bits needed to hold a step counter that counts down from n
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } divState_t;

    // Counter must represent the value n itself, hence clog2(n+1)
    function automatic int counterWidth(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_div_step.sv
// seq_div_step
// One combinational non-restoring division step.
//   partRem_i     [M:0]   current partial remainder, bit M is the sign
//   dividendBit_i         next dividend bit, shifted in at the LSB
//   divisor_i     [M-1:0] divisor magnitude
//   partRem_o     [M:0]   partial remainder after this step
//   quotBit_o             quotient bit produced by this step
module seq_div_step #(
    parameter int M = 8
) (
    input  logic [M:0]   partRem_i,
    input  logic         dividendBit_i,
    input  logic [M-1:0] divisor_i,
    output logic [M:0]   partRem_o,
    output logic         quotBit_o
);

    logic [M:0] shifted;
    logic [M:0] divisorExt;

    // The shifted value may not fit in M+1 bits, but the true result of the
    // add/subtract always lies in [-D, D), so modular M+1-bit arithmetic
    // still lands on the correct value.
    always_comb begin
        shifted    = {partRem_i[M-1:0], dividendBit_i};
        divisorExt = {1'b0, divisor_i};
        if (partRem_i[M]) begin
            partRem_o = shifted + divisorExt;
        end else begin
            partRem_o = shifted - divisorExt;
        end
        quotBit_o = ~partRem_o[M];
    end

endmodule

// File: rtl/seq_divider.sv
// seq_divider
// Multi-cycle integer divider, one quotient bit per clock (non-restoring).
//   CLK        clock, all state updates on the rising edge
//   RST        synchronous active-high reset
//   Start      request, honoured only while Busy is low
//   Signed     1 = two's-complement operands, captured with Start
//   OperA      [N-1:0] dividend, captured with Start
//   OperD      [M-1:0] divisor, captured with Start
//   Busy       operation in progress
//   Done       one-cycle pulse, results valid
//   Quotient   [N-1:0] held until the next accepted Start
//   Remainder  [M-1:0] held like Quotient
//   DivByZero  set with Done when the divisor was zero
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int DIVIDEND_LENGTH = 16,
    parameter int DIVISOR_LENGTH  = 8
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       Start,
    input  logic                       Signed,
    input  logic [DIVIDEND_LENGTH-1:0] OperA,
    input  logic [DIVISOR_LENGTH-1:0]  OperD,
    output logic                       Busy,
    output logic                       Done,
    output logic [DIVIDEND_LENGTH-1:0] Quotient,
    output logic [DIVISOR_LENGTH-1:0]  Remainder,
    output logic                       DivByZero
);

    localparam int N  = DIVIDEND_LENGTH;
    localparam int M  = DIVISOR_LENGTH;
    localparam int CW = counterWidth(N);

    divState_t      state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic [N-1:0]   dividend_q, dividend_d;
    logic [M:0]     partRem_q, partRem_d;
    logic [M-1:0]   divisorMag_q, divisorMag_d;
    logic           negQuot_q, negQuot_d;
    logic           negRem_q, negRem_d;
    logic           zeroDiv_q, zeroDiv_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [N-1:0]   quot_q, quot_d;
    logic [M-1:0]   rem_q, rem_d;
    logic           divByZero_q, divByZero_d;

    logic           dividendNeg;
    logic           divisorNeg;
    logic [N-1:0]   dividendMag;
    logic [M-1:0]   divisorMagIn;
    logic [M-1:0]   remMag;
    logic [M:0]     stepRem;
    logic           stepQuotBit;

    seq_div_step #(
        .M (M)
    ) uStep (
        .partRem_i     (partRem_q),
        .dividendBit_i (dividend_q[N-1]),
        .divisor_i     (divisorMag_q),
        .partRem_o     (stepRem),
        .quotBit_o     (stepQuotBit)
    );

    // Operand signs and magnitudes. In signed mode the most-negative values
    // still have representable magnitudes when read as unsigned.
    always_comb begin
        dividendNeg  = Signed & OperA[N-1];
        divisorNeg   = Signed & OperD[M-1];
        dividendMag  = dividendNeg ? -OperA : OperA;
        divisorMagIn = divisorNeg ? -OperD : OperD;
    end

    // A negative final remainder is corrected by adding the divisor back.
    // The true result is in [0, D), so M-bit arithmetic suffices.
    always_comb begin
        if (partRem_q[M]) begin
            remMag = partRem_q[M-1:0] + divisorMag_q;
        end else begin
            remMag = partRem_q[M-1:0];
        end
    end

    // Next-state logic. The dividend register shifts its bits out at the MSB
    // while quotient bits enter at the LSB, so after N steps it holds the
    // quotient magnitude. A zero divisor skips CALC but still passes through
    // FIX, where every result register is written.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        dividend_d   = dividend_q;
        partRem_d    = partRem_q;
        divisorMag_d = divisorMag_q;
        negQuot_d    = negQuot_q;
        negRem_d     = negRem_q;
        zeroDiv_d    = zeroDiv_q;
        quot_d       = quot_q;
        rem_d        = rem_q;
        divByZero_d  = divByZero_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (Start) begin
                    negQuot_d    = dividendNeg ^ divisorNeg;
                    negRem_d     = dividendNeg;
                    divisorMag_d = divisorMagIn;
                    partRem_d    = '0;
                    divByZero_d  = 1'b0;
                    if (OperD == '0) begin
                        zeroDiv_d  = 1'b1;
                        dividend_d = OperA;
                        state_d    = FIX;
                    end else begin
                        zeroDiv_d  = 1'b0;
                        dividend_d = dividendMag;
                        count_d    = CW'(N);
                        state_d    = CALC;
                    end
                end
            end
            CALC: begin
                partRem_d  = stepRem;
                dividend_d = {dividend_q[N-2:0], stepQuotBit};
                count_d    = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (zeroDiv_q) begin
                    quot_d      = '1;
                    rem_d       = dividend_q[M-1:0];
                    divByZero_d = 1'b1;
                end else begin
                    quot_d      = negQuot_q ? -dividend_q : dividend_q;
                    rem_d       = negRem_q ? -remMag : remMag;
                    divByZero_d = 1'b0;
                end
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == CALC) || (state_d == FIX);
        done_d = (state_d == DONE);
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            count_q      <= '0;
            dividend_q   <= '0;
            partRem_q    <= '0;
            divisorMag_q <= '0;
            negQuot_q    <= 1'b0;
            negRem_q     <= 1'b0;
            zeroDiv_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            quot_q       <= '0;
            rem_q        <= '0;
            divByZero_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            dividend_q   <= dividend_d;
            partRem_q    <= partRem_d;
            divisorMag_q <= divisorMag_d;
            negQuot_q    <= negQuot_d;
            negRem_q     <= negRem_d;
            zeroDiv_q    <= zeroDiv_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            quot_q       <= quot_d;
            rem_q        <= rem_d;
            divByZero_q  <= divByZero_d;
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Quotient  = quot_q;
    assign Remainder = rem_q;
    assign DivByZero = divByZero_q;

endmodule
